// File: rtl/lu_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides and a saturating op counter.
// Define LU_ACCUM_EN to add an accumulator that can replace operand A.
module lu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] op_count
);

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             ones_q;
    logic [CNT_W-1:0] op_count_q;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] result;
    logic             in_xfer;

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;

`ifdef LU_ACCUM_EN
    logic [WIDTH-1:0] acc_q;

    assign a_eff = acc_sel ? acc_q : a;

    // Clear wins over load; the operation in the same cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (in_xfer) begin
            acc_q <= result;
        end
    end
`else
    logic unused_acc_ports;

    assign unused_acc_ports = acc_sel ^ acc_clr;
    assign a_eff            = a;
`endif

    always_comb begin
        result = '0;
        unique case (op)
            3'b000: result = a_eff & b;
            3'b001: result = a_eff | b;
            3'b010: result = ~(a_eff & b);
            3'b011: result = ~(a_eff | b);
            3'b100: result = a_eff ^ b;
            3'b101: result = ~(a_eff ^ b);
            3'b110: result = ~a_eff;
            3'b111: result = b;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            op_count_q  <= '0;
        end else if (in_xfer) begin
            out_valid_q <= 1'b1;
            y_q         <= result;
            zero_q      <= (result == '0);
            ones_q      <= (result == '1);
            if (op_count_q != '1) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_lu_pipe.sv
// Directed self-checking bench for lu_pipe: truth table, flags, backpressure,
// accumulator or its absence, counter saturation and reset during a held result.
module tb_lu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        acc_sel;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        zero;
    logic        ones;
    logic [15:0] op_count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_y;
    logic        s_zero;
    logic        s_ones;
    logic [1:0]  s_op_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .acc_sel(acc_sel), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .zero(zero), .ones(ones), .op_count(op_count)
    );

    lu_pipe #(.WIDTH(8), .CNT_W(2)) sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(3'b111),
        .a(8'h00), .b(8'h11), .acc_sel(1'b0), .acc_clr(1'b0), .out_valid(s_out_valid),
        .out_ready(1'b1), .y(s_y), .zero(s_zero), .ones(s_ones), .op_count(s_op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle outputs before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_tt [8];

    initial begin
        exp_tt = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hCC};
        rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
        acc_sel = 1'b0; acc_clr = 1'b0; out_ready = 1'b1; s_in_valid = 1'b0;

        // Reset
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_ones", 32'(ones), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Truth table back-to-back
        a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            check($sformatf("tt_y_op%0d", i), 32'(y), 32'(exp_tt[i]));
            check($sformatf("tt_valid_op%0d", i), 32'(out_valid), 32'd1);
        end
        check("tt_op_count", 32'(op_count), 32'd8);

        // Flags
        a = 8'h00; b = 8'hFF; op = 3'b000;
        step();
        check("flag_and_y", 32'(y), 32'h00);
        check("flag_and_zero", 32'(zero), 32'd1);
        check("flag_and_ones", 32'(ones), 32'd0);
        op = 3'b001;
        step();
        check("flag_or_y", 32'(y), 32'hFF);
        check("flag_or_zero", 32'(zero), 32'd0);
        check("flag_or_ones", 32'(ones), 32'd1);

        // Drain, then backpressure
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_y_hold", 32'(y), 32'hFF);
        out_ready = 1'b0; in_valid = 1'b1; a = 8'hAA; b = 8'h55; op = 3'b001;
        step();
        check("bp_first_y", 32'(y), 32'hFF);
        check("bp_first_count", 32'(op_count), 32'd11);
        op = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp_hold_y%0d", i), 32'(y), 32'hFF);
            check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_count%0d", i), 32'(op_count), 32'd11);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_second_y", 32'(y), 32'h00);
        check("bp_second_zero", 32'(zero), 32'd1);
        check("bp_second_count", 32'(op_count), 32'd12);

`ifdef LU_ACCUM_EN
        in_valid = 1'b0; acc_clr = 1'b1;
        step();
        acc_clr = 1'b0; in_valid = 1'b1; acc_sel = 1'b1; op = 3'b001; a = 8'h80;
        b = 8'h01; step(); check("acc_y1", 32'(y), 32'h01);
        b = 8'h02; step(); check("acc_y2", 32'(y), 32'h03);
        b = 8'h04; step(); check("acc_y3", 32'(y), 32'h07);
        b = 8'h08; acc_clr = 1'b1; step(); check("acc_y4_clr", 32'(y), 32'h0F);
        acc_clr = 1'b0; b = 8'h10; step(); check("acc_y5", 32'(y), 32'h10);
        acc_sel = 1'b0;
`else
        // Accumulator absent: acc_sel and acc_clr must not affect the result.
        acc_sel = 1'b1; acc_clr = 1'b1; a = 8'h3C; b = 8'hFF; op = 3'b000;
        step(); check("noacc_y1", 32'(y), 32'h3C);
        a = 8'h81; op = 3'b001; b = 8'h02;
        step(); check("noacc_y2", 32'(y), 32'h83);
        acc_sel = 1'b0; acc_clr = 1'b0;
`endif

        // Reset while a result is held under backpressure
        op = 3'b111; b = 8'h5A; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("mid_post_valid", 32'(out_valid), 32'd0);

        // Saturation with CNT_W = 2
        s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat_count%0d", i), 32'(s_op_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        s_in_valid = 1'b0;
        check("sat_y", 32'(s_y), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
